// File: rtl/cpu0_io_pkg.sv
// Shared definitions for the cpu0 memory-mapped character output device.
package cpu0_io_pkg;

  // m_size encodings driven by the core
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_INT16 = 2'b01,
    SZ_INT24 = 2'b10,
    SZ_INT32 = 2'b11
  } msize_t;

  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0008_0000;

  // Bit positions inside the status word returned at IO_ADDR+4
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVERRUN = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic {
    UP_IDLE,
    UP_UNPACK
  } up_state_t;

  // Which bytes of a written word get queued: bit i set => byte i is pushed.
  // Byte writes always push; wider writes push nothing when byte0 is zero,
  // otherwise byte0 plus every nonzero higher byte within the access width.
  function automatic logic [3:0] unpack_mask(input logic [31:0] word, input msize_t size);
    logic [3:0] m;
    m = '0;
    if (size == SZ_BYTE) begin
      m = 4'b0001;
    end else if (word[7:0] != 8'h00) begin
      m[0] = 1'b1;
      m[1] = (word[15:8] != 8'h00);
      m[2] = (size != SZ_INT16) && (word[23:16] != 8'h00);
      m[3] = (size == SZ_INT32) && (word[31:24] != 8'h00);
    end
    return m;
  endfunction

endpackage

// File: rtl/cpu0_byte_fifo.sv
// 8-bit synchronous byte FIFO with show-ahead read data.
module cpu0_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        wr_en;
  logic        rd_en;

  // A push while full is only taken when a pop frees a slot in the same cycle
  always_comb begin
    wr_en = push && (!full || pop);
    rd_en = pop && !empty;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB separates full from empty after wrap-around
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu0_uart_tx.sv
// Memory-mapped character output: snoops core writes to IO_ADDR, unpacks the
// bytes into a FIFO and serialises them as 8N1 frames on txd.
module cpu0_uart_tx
  import cpu0_io_pkg::*;
#(
  parameter logic [31:0] IO_ADDR      = IO_ADDR_DEFAULT,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m_en,
  input  logic        m_rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        txd,
  output logic        tx_busy
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] STAT_ADDR = IO_ADDR + 32'd4;

  logic            wr_hit;
  logic            wr_hit_q;
  logic            accept;
  logic            wr_stat;
  logic            rd_stat;

  up_state_t       up_state;
  logic [31:0]     up_word;
  logic [3:0]      up_mask;
  logic [3:0]      cur_bit;
  logic [3:0]      accept_mask;
  logic            push;
  logic [7:0]      push_data;

  logic            pop;
  logic [7:0]      pop_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic            overrun;

  tx_state_t       tx_state;
  logic [BW-1:0]   baud_cnt;
  logic            baud_end;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            txd_r;
  logic [31:0]     status;

  // Bus decode
  always_comb begin
    wr_hit      = m_en && !m_rw && (abus == IO_ADDR);
    wr_stat     = m_en && !m_rw && (abus == STAT_ADDR);
    rd_stat     = m_en &&  m_rw && (abus == STAT_ADDR);
    accept      = wr_hit && !wr_hit_q;
    accept_mask = unpack_mask(dbus_in, msize_t'(m_size));
  end

  // Previous-edge write hit, so a held strobe is one write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_hit_q <= 1'b0;
    else       wr_hit_q <= wr_hit;
  end

  // Lowest pending byte of the latched word is the one pushed this cycle
  always_comb begin
    cur_bit   = '0;
    push_data = up_word[7:0];
    if (up_mask[0]) begin
      cur_bit = 4'b0001; push_data = up_word[7:0];
    end else if (up_mask[1]) begin
      cur_bit = 4'b0010; push_data = up_word[15:8];
    end else if (up_mask[2]) begin
      cur_bit = 4'b0100; push_data = up_word[23:16];
    end else if (up_mask[3]) begin
      cur_bit = 4'b1000; push_data = up_word[31:24];
    end
    push = (up_state == UP_UNPACK);
  end

  // Unpacker: latch word on accept, then push one byte per cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      up_state <= UP_IDLE;
      up_word  <= '0;
      up_mask  <= '0;
    end else begin
      case (up_state)
        UP_IDLE: begin
          if (accept && (accept_mask != 4'b0000)) begin
            up_state <= UP_UNPACK;
            up_word  <= dbus_in;
            up_mask  <= accept_mask;
          end
        end
        UP_UNPACK: begin
          up_mask <= up_mask & ~cur_bit;
          if ((up_mask & ~cur_bit) == 4'b0000) up_state <= UP_IDLE;
        end
        default: up_state <= UP_IDLE;
      endcase
    end
  end

  cpu0_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sticky overrun; a new overrun event beats a simultaneous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if ((accept && (up_state == UP_UNPACK)) || (push && fifo_full && !pop)) begin
      overrun <= 1'b1;
    end else if (wr_stat) begin
      overrun <= 1'b0;
    end
  end

  // Pop when the line is free: from idle, or at the end of a stop bit
  always_comb begin
    baud_end = (baud_cnt == BAUD_LAST);
    pop      = !fifo_empty &&
               ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && baud_end));
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      txd_r    <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            shreg    <= pop_data;
            txd_r    <= 1'b0;
            baud_cnt <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd_r    <= shreg[0];
            tx_state <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              txd_r    <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd_r   <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        TX_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg    <= pop_data;
              txd_r    <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          txd_r    <= 1'b1;
        end
      endcase
    end
  end

  assign txd     = txd_r;
  assign tx_busy = (tx_state != TX_IDLE);

  // Status word
  always_comb begin
    status             = '0;
    status[ST_EMPTY]   = fifo_empty;
    status[ST_FULL]    = fifo_full;
    status[ST_BUSY]    = tx_busy;
    status[ST_OVERRUN] = overrun;
  end

  assign dbus_out = rd_stat ? status : 'z;

endmodule

// File: tb/tb_cpu0_uart_tx.sv
// Directed bench for cpu0_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
module tb_cpu0_uart_tx;

  localparam int CPB = 4;
  localparam logic [31:0] IO   = 32'h0008_0000;
  localparam logic [31:0] STAT = 32'h0008_0004;

  logic        clock;
  logic        reset;
  logic        m_en;
  logic        m_rw;
  logic [1:0]  m_size;
  logic [31:0] abus;
  logic [31:0] dbus_in;
  logic [31:0] dbus_out;
  logic        txd;
  logic        tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] frame_q[$];
  int         start_q[$];
  bit         shape_q[$];

  cpu0_uart_tx #(
    .IO_ADDR     (IO),
    .DEPTH       (4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m_en    (m_en),
    .m_rw    (m_rw),
    .m_size  (m_size),
    .abus    (abus),
    .dbus_in (dbus_in),
    .dbus_out(dbus_out),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Line monitor: decode every frame seen on txd (mid-bit sampling)
  initial begin
    logic [7:0] b;
    int s;
    bit ok;
    forever begin
      @(negedge clock);
      if (txd === 1'b0) begin
        s  = cyc;
        ok = 1'b1;
        repeat (CPB/2) @(negedge clock);
        if (txd !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clock);
          b[k] = txd;
        end
        repeat (CPB) @(negedge clock);
        if (txd !== 1'b1) ok = 1'b0;
        frame_q.push_back(b);
        start_q.push_back(s);
        shape_q.push_back(ok);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fq(input int i);
    return (i < frame_q.size()) ? frame_q[i] : 8'hxx;
  endfunction

  function automatic int sq(input int i);
    return (i < start_q.size()) ? start_q[i] : -1000;
  endfunction

  task automatic clear_mon();
    frame_q.delete();
    start_q.delete();
    shape_q.delete();
  endtask

  // One-cycle write strobe; wc is the cycle count at the setup negedge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, output int wc);
    @(negedge clock);
    m_en = 1'b1; m_rw = 1'b0; abus = a; dbus_in = d; m_size = sz;
    wc = cyc;
    @(negedge clock);
    m_en = 1'b0; abus = '0;
  endtask

  // Status read, called just after a negedge
  task automatic status_read(output logic [31:0] v);
    m_en = 1'b1; m_rw = 1'b1; abus = STAT;
    #1 v = dbus_out;
    #1 m_en = 1'b0; m_rw = 1'b0; abus = '0;
  endtask

  // Wait for the transmitter to drain; returns cycle of first idle negedge
  task automatic wait_done(input string tag, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 600 && !got; i++) begin
      if (tx_busy === 1'b0) begin
        got = 1'b1;
        at  = cyc;
      end else begin
        @(negedge clock);
      end
    end
    check({tag, "_drained"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] st;
    int wc;
    int done;
    int nsz;
    int later;

    reset = 1'b1; m_en = 1'b0; m_rw = 1'b0; m_size = 2'b00;
    abus = '0; dbus_in = '0;
    repeat (3) @(negedge clock);
    check("rst_txd", 32'(txd), 32'd1);
    reset = 1'b0;
    @(negedge clock);

    // 1: status after reset
    status_read(st);
    check("t1_status", st, 32'h1);
    check("t1_txd", 32'(txd), 32'd1);
    check("t1_busy", 32'(tx_busy), 32'd0);

    // 2: three-byte word, back-to-back frames
    clear_mon();
    bus_write(IO, 32'h0043_4241, 2'b11, wc);
    wait_done("t2", done);
    check("t2_count", 32'(frame_q.size()), 32'd3);
    check("t2_b0", 32'(fq(0)), 32'h41);
    check("t2_b1", 32'(fq(1)), 32'h42);
    check("t2_b2", 32'(fq(2)), 32'h43);
    check("t2_latency", 32'(sq(0) - wc), 32'd3);
    check("t2_gap01", 32'(sq(1) - sq(0)), 32'd40);
    check("t2_gap12", 32'(sq(2) - sq(1)), 32'd40);
    check("t2_total", 32'(done - sq(0)), 32'd120);
    check("t2_shape", 32'(shape_q.size() == 3 && shape_q[0] && shape_q[1] && shape_q[2]), 32'd1);
    check("t2_txd_idle", 32'(txd), 32'd1);

    // 3: zero bytes skipped; zero byte0 pushes nothing
    clear_mon();
    bus_write(IO, 32'h4400_0041, 2'b11, wc);
    wait_done("t3", done);
    check("t3_count", 32'(frame_q.size()), 32'd2);
    check("t3_b0", 32'(fq(0)), 32'h41);
    check("t3_b1", 32'(fq(1)), 32'h44);
    clear_mon();
    bus_write(IO, 32'h0000_4200, 2'b11, wc);
    repeat (60) @(negedge clock);
    check("t3_nullword", 32'(frame_q.size()), 32'd0);
    status_read(st);
    check("t3_status", st, 32'h1);

    // 4: byte 0x00 is sent; INT16 with zero byte0 is not
    clear_mon();
    bus_write(IO, 32'h0000_0000, 2'b00, wc);
    wait_done("t4", done);
    check("t4_count", 32'(frame_q.size()), 32'd1);
    check("t4_byte", 32'(fq(0)), 32'h00);
    check("t4_shape", 32'(shape_q.size() == 1 && shape_q[0]), 32'd1);
    clear_mon();
    bus_write(IO, 32'h0000_FF00, 2'b01, wc);
    repeat (60) @(negedge clock);
    check("t4_nullint16", 32'(frame_q.size()), 32'd0);

    // 5: six byte writes into a 4-deep FIFO -> one dropped, overrun
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      bus_write(IO, 32'h0000_0061, 2'b00, wc);
      repeat (2) @(negedge clock);
    end
    status_read(st);
    check("t5_status_ovr", st, 32'hE);
    bus_write(STAT, 32'h0, 2'b11, wc);
    @(negedge clock);
    status_read(st);
    check("t5_status_clr", st, 32'h6);
    wait_done("t5", done);
    check("t5_count", 32'(frame_q.size()), 32'd5);
    check("t5_b0", 32'(fq(0)), 32'h61);
    check("t5_b4", 32'(fq(4)), 32'h61);
    check("t5_total", 32'(done - sq(0)), 32'd200);

    // 6: reset in the middle of the data bits of a 2-byte burst
    clear_mon();
    bus_write(IO, 32'h0000_6261, 2'b01, wc);
    while (cyc < wc + 3 + 10) @(negedge clock);
    check("t6_mid_bit1", 32'(txd), 32'd0);
    check("t6_busy_pre", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_txd_async", 32'(txd), 32'd1);
    check("t6_busy_async", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    nsz   = start_q.size();
    later = 0;
    for (int i = 0; i < nsz; i++) if (start_q[i] > wc + 3) later++;
    check("t6_no_more_frames", 32'(later), 32'd0);
    status_read(st);
    check("t6_status", st, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
